// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: arbitrates branch/jump redirects, load-use stalls and
// halt/resume for the PC and instruction-memory block, and sequences the boot vector.
// Optional performance counters are built only when FETCH_PERF_CNT_EN is defined.
module fetch_ctrl #(
    parameter int unsigned          ADDR_W          = 16,
    parameter logic [ADDR_W-1:0]    RESET_VEC       = ADDR_W'(16'h0008),
    parameter int unsigned          LD_STALL_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              br_req,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              jmp_req,
    input  logic [ADDR_W-1:0] jmp_target,
    input  logic              hz_load_use,
    input  logic              halt_req,
    input  logic              resume,
    output logic              pc_mux_sel,
    output logic [ADDR_W-1:0] jmp_loc,
    output logic              stall,
    output logic              stall_pm,
    output logic              flush_if,
    output logic              flush_id,
    output logic              halted,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       redir_cnt
);

    localparam logic [1:0] StBoot    = 2'd0;
    localparam logic [1:0] StRun     = 2'd1;
    localparam logic [1:0] StLdStall = 2'd2;
    localparam logic [1:0] StHalt    = 2'd3;

    // The request cycle is the first freeze cycle, so LD_STALL covers the remaining ones.
    localparam logic [3:0] LdCntInit =
        (LD_STALL_CYCLES > 1) ? 4'(LD_STALL_CYCLES - 2) : 4'd0;

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] state_eff;

    // Next-state and Mealy output decode; reset low forces BOOT behaviour immediately.
    always_comb begin
        state_eff  = reset ? state_q : StBoot;
        state_d    = state_eff;
        cnt_d      = cnt_q;
        pc_mux_sel = 1'b0;
        jmp_loc    = '0;
        stall      = 1'b0;
        stall_pm   = 1'b0;
        flush_if   = 1'b0;
        flush_id   = 1'b0;
        halted     = 1'b0;
        case (state_eff)
            StBoot: begin
                pc_mux_sel = 1'b1;
                jmp_loc    = RESET_VEC;
                flush_if   = 1'b1;
                flush_id   = 1'b1;
                state_d    = StRun;
            end
            StRun: begin
                if (br_req) begin
                    pc_mux_sel = 1'b1;
                    jmp_loc    = br_target;
                    flush_if   = 1'b1;
                    flush_id   = 1'b1;
                end else if (jmp_req) begin
                    pc_mux_sel = 1'b1;
                    jmp_loc    = jmp_target;
                    flush_if   = 1'b1;
                end else if (hz_load_use) begin
                    stall    = 1'b1;
                    stall_pm = 1'b1;
                    flush_id = 1'b1;
                    if (LD_STALL_CYCLES > 1) begin
                        state_d = StLdStall;
                        cnt_d   = LdCntInit;
                    end
                end else if (halt_req) begin
                    stall    = 1'b1;
                    stall_pm = 1'b1;
                    flush_id = 1'b1;
                    state_d  = StHalt;
                end
            end
            StLdStall: begin
                // Jump/hazard/halt are re-presented by the held ID instruction later.
                if (br_req) begin
                    pc_mux_sel = 1'b1;
                    jmp_loc    = br_target;
                    flush_if   = 1'b1;
                    flush_id   = 1'b1;
                    state_d    = StRun;
                end else begin
                    stall    = 1'b1;
                    stall_pm = 1'b1;
                    flush_id = 1'b1;
                    if (cnt_q == 4'd0) begin
                        state_d = StRun;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            StHalt: begin
                stall    = 1'b1;
                stall_pm = 1'b1;
                flush_id = 1'b1;
                halted   = 1'b1;
                if (resume) begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    // State and stall down-counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StBoot;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] redir_cnt_q;

    // Saturating performance counters for stall cycles and redirects.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= 16'h0000;
            redir_cnt_q <= 16'h0000;
        end else begin
            if (stall && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (pc_mux_sel && (state_eff != StBoot) && (redir_cnt_q != 16'hFFFF)) begin
                redir_cnt_q <= redir_cnt_q + 16'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign redir_cnt = redir_cnt_q;
`else
    assign stall_cnt = 16'h0000;
    assign redir_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl (LD_STALL_CYCLES=3): stimulus pushes the expected
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_fetch_ctrl;

`ifdef FETCH_PERF_CNT_EN
    localparam int Perf = 1;
`else
    localparam int Perf = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        br_req = 1'b0;
    logic [15:0] br_target = 16'h0;
    logic        jmp_req = 1'b0;
    logic [15:0] jmp_target = 16'h0;
    logic        hz_load_use = 1'b0;
    logic        halt_req = 1'b0;
    logic        resume = 1'b0;
    logic        pc_mux_sel;
    logic [15:0] jmp_loc;
    logic        stall;
    logic        stall_pm;
    logic        flush_if;
    logic        flush_id;
    logic        halted;
    logic [15:0] stall_cnt;
    logic [15:0] redir_cnt;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       nm;
        bit          chk;
        logic [21:0] v;
        bit          cc;
        logic [15:0] sc;
        logic [15:0] rc;
    } exp_t;

    exp_t exp_q[$];

    fetch_ctrl #(
        .ADDR_W          (16),
        .RESET_VEC       (16'h0008),
        .LD_STALL_CYCLES (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .br_req      (br_req),
        .br_target   (br_target),
        .jmp_req     (jmp_req),
        .jmp_target  (jmp_target),
        .hz_load_use (hz_load_use),
        .halt_req    (halt_req),
        .resume      (resume),
        .pc_mux_sel  (pc_mux_sel),
        .jmp_loc     (jmp_loc),
        .stall       (stall),
        .stall_pm    (stall_pm),
        .flush_if    (flush_if),
        .flush_id    (flush_id),
        .halted      (halted),
        .stall_cnt   (stall_cnt),
        .redir_cnt   (redir_cnt)
    );

    always #5 clk = ~clk;

    // Expected vector layout: {pc_mux_sel, jmp_loc, stall, stall_pm, flush_if, flush_id, halted}
    function automatic logic [21:0] ev(input logic pms, input logic [15:0] loc, input logic st,
                                       input logic fi, input logic fd, input logic h);
        return {pms, loc, st, st, fi, fd, h};
    endfunction

    logic [21:0] zv, bootv, stallv, haltv;

    // One cycle: drive inputs just after the edge and queue the expected response.
    task automatic step(input string nm, input logic rst_v, input logic [3:0] req,
                        input logic res_v, input logic [15:0] bt, input logic [15:0] jt,
                        input bit chk, input logic [21:0] v, input bit cc,
                        input int sc, input int rc);
        exp_t e;
        @(posedge clk);
        #1;
        reset       = rst_v;
        br_req      = req[3];
        jmp_req     = req[2];
        hz_load_use = req[1];
        halt_req    = req[0];
        resume      = res_v;
        br_target   = bt;
        jmp_target  = jt;
        e.nm  = nm;
        e.chk = chk;
        e.v   = v;
        e.cc  = cc;
        e.sc  = 16'(sc * Perf);
        e.rc  = 16'(rc * Perf);
        exp_q.push_back(e);
    endtask

    // Monitor: every cycle with a queued expectation is compared mid-cycle.
    always @(negedge clk) begin
        exp_t        e;
        logic [21:0] act;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {pc_mux_sel, jmp_loc, stall, stall_pm, flush_if, flush_id, halted};
            if (e.chk) begin
                checks++;
                if (act !== e.v) begin
                    failures++;
                    $display("FAIL %s: outputs got %h expected %h", e.nm, act, e.v);
                end
            end
            if (e.cc) begin
                checks++;
                if ((stall_cnt !== e.sc) || (redir_cnt !== e.rc)) begin
                    failures++;
                    $display("FAIL %s_cnt: stall_cnt/redir_cnt got %0d/%0d expected %0d/%0d",
                             e.nm, stall_cnt, redir_cnt, e.sc, e.rc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        zv     = ev(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        bootv  = ev(1'b1, 16'h0008, 1'b0, 1'b1, 1'b1, 1'b0);
        stallv = ev(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        haltv  = ev(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);

        // Reset and boot vector
        step("rst0",  1'b0, 4'b0000, 1'b0, 16'h0, 16'h0, 1, bootv, 0, 0, 0);
        step("rst1",  1'b0, 4'b0000, 1'b0, 16'h0, 16'h0, 1, bootv, 1, 0, 0);
        step("boot",  1'b1, 4'b0000, 1'b0, 16'h0, 16'h0, 1, bootv, 1, 0, 0);
        step("run0",  1'b1, 4'b0000, 1'b0, 16'h0, 16'h0, 1, zv, 1, 0, 0);
        // Jump, then branch+jump collision, then branch+hazard
        step("jmp",   1'b1, 4'b0100, 1'b0, 16'h0, 16'h0020, 1,
             ev(1'b1, 16'h0020, 1'b0, 1'b1, 1'b0, 1'b0), 0, 0, 0);
        step("idle1", 1'b1, 4'b0000, 1'b0, 16'h0, 16'h0, 1, zv, 1, 0, 1);
        step("brjmp", 1'b1, 4'b1100, 1'b0, 16'h0040, 16'h0020, 1,
             ev(1'b1, 16'h0040, 1'b0, 1'b1, 1'b1, 1'b0), 0, 0, 0);
        step("idle2", 1'b1, 4'b0000, 1'b0, 16'h0, 16'h0, 1, zv, 1, 0, 2);
        step("brhz",  1'b1, 4'b1010, 1'b0, 16'h0050, 16'h0, 1,
             ev(1'b1, 16'h0050, 1'b0, 1'b1, 1'b1, 1'b0), 0, 0, 0);
        // Three-cycle load-use freeze
        step("hz1",   1'b1, 4'b0010, 1'b0, 16'h0, 16'h0, 1, stallv, 1, 0, 3);
        step("hz2",   1'b1, 4'b0000, 1'b0, 16'h0, 16'h0, 1, stallv, 1, 1, 3);
        step("hz3",   1'b1, 4'b0000, 1'b0, 16'h0, 16'h0, 1, stallv, 1, 2, 3);
        step("hzend", 1'b1, 4'b0000, 1'b0, 16'h0, 16'h0, 1, zv, 1, 3, 3);
        // Branch in stall cycle 2 aborts the freeze
        step("hzb1",  1'b1, 4'b0010, 1'b0, 16'h0, 16'h0, 1, stallv, 0, 0, 0);
        step("hzbr",  1'b1, 4'b1000, 1'b0, 16'h0060, 16'h0, 1,
             ev(1'b1, 16'h0060, 1'b0, 1'b1, 1'b1, 1'b0), 1, 4, 3);
        step("hzbend", 1'b1, 4'b0000, 1'b0, 16'h0, 16'h0, 1, zv, 1, 4, 4);
        // Jump and halt during a freeze are ignored
        step("hzi1",  1'b1, 4'b0010, 1'b0, 16'h0, 16'h0, 1, stallv, 0, 0, 0);
        step("hzi2",  1'b1, 4'b0101, 1'b0, 16'h0, 16'h0070, 1, stallv, 0, 0, 0);
        step("hzi3",  1'b1, 4'b0000, 1'b0, 16'h0, 16'h0, 1, stallv, 0, 0, 0);
        step("hziend", 1'b1, 4'b0000, 1'b0, 16'h0, 16'h0, 1, zv, 1, 7, 4);
        // Reset from RUN clears the counters
        step("rstr",  1'b0, 4'b0000, 1'b0, 16'h0, 16'h0, 0, zv, 0, 0, 0);
        step("bootr", 1'b1, 4'b0000, 1'b0, 16'h0, 16'h0, 1, bootv, 1, 0, 0);
        step("runr",  1'b1, 4'b0000, 1'b0, 16'h0, 16'h0, 1, zv, 1, 0, 0);
        // Halt, five held cycles (one with an ignored branch), then resume
        step("halt",  1'b1, 4'b0001, 1'b0, 16'h0, 16'h0, 1, stallv, 0, 0, 0);
        step("hlt1",  1'b1, 4'b0000, 1'b0, 16'h0, 16'h0, 1, haltv, 1, 1, 0);
        step("hlt2",  1'b1, 4'b1000, 1'b0, 16'h0080, 16'h0, 1, haltv, 0, 0, 0);
        step("hlt3",  1'b1, 4'b0000, 1'b0, 16'h0, 16'h0, 1, haltv, 0, 0, 0);
        step("hlt4",  1'b1, 4'b0000, 1'b0, 16'h0, 16'h0, 1, haltv, 0, 0, 0);
        step("hlt5",  1'b1, 4'b0000, 1'b0, 16'h0, 16'h0, 1, haltv, 0, 0, 0);
        step("resume", 1'b1, 4'b0000, 1'b1, 16'h0, 16'h0, 1, haltv, 1, 6, 0);
        step("postres", 1'b1, 4'b0000, 1'b0, 16'h0, 16'h0, 1, zv, 1, 7, 0);
        // Reset pulse while halted
        step("halt2", 1'b1, 4'b0001, 1'b0, 16'h0, 16'h0, 1, stallv, 0, 0, 0);
        step("hlt21", 1'b1, 4'b0000, 1'b0, 16'h0, 16'h0, 1, haltv, 0, 0, 0);
        step("rsth",  1'b0, 4'b0000, 1'b0, 16'h0, 16'h0, 0, zv, 0, 0, 0);
        step("booth", 1'b1, 4'b0000, 1'b0, 16'h0, 16'h0, 1, bootv, 1, 0, 0);
        step("runh",  1'b1, 4'b0000, 1'b0, 16'h0, 16'h0, 1, zv, 1, 0, 0);

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: queue depth got %0d expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
